// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and parity helper for the PS/2 keyboard decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  localparam int KEY_EXT     = 8;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_TOGGLE  = 10;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic oddParityOk(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a level filter that only accepts a new
// level after FILTER_LEN consecutive equal synchronized samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic line_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample that agrees with the current level restarts the run.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign line_o = level_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: filters both lines, deframes 11-bit frames and
// folds E0/F0 prefixes into an 11-bit key event word.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 48000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        parity_err,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic clkF;
  logic dataF;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uClkFilter (
    .clk_i (clk_sys),
    .rst_ni(reset_n),
    .line_i(ps2_clk),
    .line_o(clkF)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uDataFilter (
    .clk_i (clk_sys),
    .rst_ni(reset_n),
    .line_i(ps2_data),
    .line_o(dataF)
  );

  ps2_state_e    state_q, state_d;
  logic          clkPrev_q;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d;
  logic          rel_q, rel_d;
  logic [10:0]   key_q, key_d;
  logic [7:0]    rxByte_q, rxByte_d;
  logic          rxValid_q, parityErr_q, frameErr_q;

  logic fall;
  logic timeout;
  logic stopFall;
  logic parOk;
  logic byteOk;
  logic parityBad;
  logic frameBad;

  assign fall     = clkPrev_q & ~clkF;
  assign timeout  = (state_q != IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign stopFall = (state_q == STOP) && fall;
  assign parOk    = oddParityOk(shift_q, parity_q);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall && !dataF) state_d = DATA;
      DATA:    if (fall && bitCnt_q == 3'd7) state_d = PARITY;
      PARITY:  if (fall) state_d = STOP;
      STOP:    if (fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  // Parity wins over a bad stop bit so an aborted frame raises exactly one error.
  always_comb begin
    byteOk    = stopFall && parOk && dataF;
    parityBad = stopFall && !parOk;
    frameBad  = timeout
             || (stopFall && parOk && !dataF)
             || (state_q == IDLE && fall && dataF);
  end

  always_comb begin
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tmo_d    = '0;
    if (state_q != IDLE && !fall && !timeout) tmo_d = tmo_q + TW'(1);
    case (state_q)
      IDLE: if (fall && !dataF) begin
        bitCnt_d = '0;
        shift_d  = '0;
      end
      DATA: if (fall) begin
        shift_d  = {dataF, shift_q[7:1]};
        bitCnt_d = bitCnt_q + 3'd1;
      end
      PARITY: if (fall) parity_d = dataF;
      default: ;
    endcase
  end

  always_comb begin
    ext_d    = ext_q;
    rel_d    = rel_q;
    key_d    = key_q;
    rxByte_d = rxByte_q;
    if (byteOk) begin
      rxByte_d = shift_q;
      if (shift_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == PS2_REL) begin
        rel_d = 1'b1;
      end else begin
        key_d[7:0]         = shift_q;
        key_d[KEY_EXT]     = ext_q;
        key_d[KEY_PRESSED] = ~rel_q;
        key_d[KEY_TOGGLE]  = ~key_q[KEY_TOGGLE];
        ext_d              = 1'b0;
        rel_d              = 1'b0;
      end
    end else if (parityBad || frameBad) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clkPrev_q   <= 1'b1;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      key_q       <= '0;
      rxByte_q    <= '0;
      rxValid_q   <= 1'b0;
      parityErr_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      clkPrev_q   <= clkF;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      key_q       <= key_d;
      rxByte_q    <= rxByte_d;
      rxValid_q   <= byteOk;
      parityErr_q <= parityBad;
      frameErr_q  <= frameBad;
    end
  end

  assign ps2_key    = key_q;
  assign rx_byte    = rxByte_q;
  assign rx_valid   = rxValid_q;
  assign parity_err = parityErr_q;
  assign frame_err  = frameErr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench: stimulus pushes expected events from a behavioural key
// model, a monitor pops and compares whenever the decoder raises a pulse.
module tb_ps2_key_decoder;

  localparam int HALF = 20;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        parity_err;
  logic        frame_err;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(48000)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef enum int {EV_VALID = 1, EV_PARITY = 2, EV_FRAME = 3} evKind_t;
  typedef struct {
    evKind_t     kind;
    logic [7:0]  rxByte;
    logic [10:0] key;
  } expEvent_t;

  expEvent_t   expQ[$];
  int          checks   = 0;
  int          failures = 0;
  logic        modelExt = 1'b0;
  logic        modelRel = 1'b0;
  logic [10:0] modelKey = '0;
  logic [7:0]  modelLast = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // One device-driven bit: data set while clock high, then a low half period.
  task automatic clockBit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      waitCycles(5);
      ps2_clk = 1'b0;
      waitCycles(3);
      ps2_clk = 1'b1;
      waitCycles(HALF - 8);
    end else begin
      waitCycles(HALF);
    end
    ps2_clk = 1'b0;
    waitCycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic pushError(input evKind_t kind);
    expEvent_t e;
    modelExt = 1'b0;
    modelRel = 1'b0;
    e.kind   = kind;
    e.rxByte = modelLast;
    e.key    = modelKey;
    expQ.push_back(e);
  endtask

  task automatic modelFrame(input logic [7:0] b, input logic badPar, input logic badStop);
    expEvent_t e;
    if (badPar) begin
      pushError(EV_PARITY);
    end else if (badStop) begin
      pushError(EV_FRAME);
    end else begin
      modelLast = b;
      if (b == 8'hE0) begin
        modelExt = 1'b1;
      end else if (b == 8'hF0) begin
        modelRel = 1'b1;
      end else begin
        modelKey[7:0] = b;
        modelKey[8]   = modelExt;
        modelKey[9]   = !modelRel;
        modelKey[10]  = !modelKey[10];
        modelExt      = 1'b0;
        modelRel      = 1'b0;
      end
      e.kind   = EV_VALID;
      e.rxByte = modelLast;
      e.key    = modelKey;
      expQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic badPar, input logic badStop,
                               input logic glitch);
    modelFrame(b, badPar, badStop);
    clockBit(1'b0, glitch);
    for (int i = 0; i < 8; i++) clockBit(b[i], glitch);
    clockBit((~^b) ^ badPar, glitch);
    clockBit(~badStop, glitch);
    ps2_data = 1'b1;
    waitCycles(2 * HALF);
  endtask

  always @(negedge clk_sys) begin : monitor
    expEvent_t e;
    evKind_t   act;
    if (reset_n && (rx_valid || parity_err || frame_err)) begin
      checkOutput("one_pulse", 32'(rx_valid) + 32'(parity_err) + 32'(frame_err), 32'd1);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_event", {29'd0, rx_valid, parity_err, frame_err}, 32'd0);
      end else begin
        e   = expQ.pop_front();
        act = rx_valid ? EV_VALID : (parity_err ? EV_PARITY : EV_FRAME);
        checkOutput("event_kind", 32'(act), 32'(e.kind));
        checkOutput("rx_byte", 32'(rx_byte), 32'(e.rxByte));
        checkOutput("ps2_key", 32'(ps2_key), 32'(e.key));
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int         sel;
    int         err;

    waitCycles(5);
    checkOutput("reset_ps2_key", 32'(ps2_key), 32'h0);
    checkOutput("reset_rx_byte", 32'(rx_byte), 32'h0);
    checkOutput("reset_pulses", {29'd0, rx_valid, parity_err, frame_err}, 32'd0);
    reset_n = 1'b1;
    waitCycles(20);

    $display("[TB] directed frames");
    applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hE0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h75, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h1C, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hE0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h33, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'hE1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h44, 1'b1, 1'b1, 1'b0);

    $display("[TB] idle fall with data high");
    pushError(EV_FRAME);
    clockBit(1'b1, 1'b0);
    waitCycles(2 * HALF);

    $display("[TB] clock glitches");
    for (int i = 0; i < 5; i++) begin
      ps2_clk = 1'b0;
      waitCycles(3);
      ps2_clk = 1'b1;
      waitCycles(15);
    end
    applyStimulus(8'h4B, 1'b0, 1'b0, 1'b1);

    $display("[TB] timeout mid-frame");
    pushError(EV_FRAME);
    clockBit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) clockBit(1'b1, 1'b0);
    ps2_data = 1'b1;
    waitCycles(48000 + 200);
    applyStimulus(8'h29, 1'b0, 1'b0, 1'b0);

    $display("[TB] random frames");
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 9);
      err = $urandom_range(0, 9);
      b   = 8'($urandom);
      if (sel == 0) b = 8'hE0;
      else if (sel == 1) b = 8'hF0;
      applyStimulus(b, err == 0, err == 1, 1'b0);
    end

    $display("[TB] reset mid-frame");
    clockBit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) clockBit(1'b0, 1'b0);
    reset_n = 1'b0;
    modelExt  = 1'b0;
    modelRel  = 1'b0;
    modelKey  = '0;
    modelLast = '0;
    waitCycles(5);
    checkOutput("midreset_ps2_key", 32'(ps2_key), 32'h0);
    checkOutput("midreset_rx_byte", 32'(rx_byte), 32'h0);
    checkOutput("midreset_pulses", {29'd0, rx_valid, parity_err, frame_err}, 32'd0);
    checkOutput("midreset_pending", 32'(expQ.size()), 32'd0);
    ps2_data = 1'b1;
    waitCycles(5);
    reset_n = 1'b1;
    waitCycles(20);
    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0);

    waitCycles(100);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: clk_sys cycles a line must hold a new level before it is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 48000: idle clk_sys cycles mid-frame before the frame is aborted (2 ms at 24 MHz).
REQ-003 SHALL have port clk_sys, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port ps2_clk, input, 1: raw PS/2 device clock, asynchronous to clk_sys.
REQ-006 SHALL have port ps2_data, input, 1: raw PS/2 device data, asynchronous to clk_sys.
REQ-007 SHALL have port ps2_key, output, 11: [7:0] scancode, [8] extended, [9] pressed, [10] toggles on every press/release event.
REQ-008 SHALL have port rx_byte, output, 8: last correctly received raw byte, prefixes included.
REQ-009 SHALL have port rx_valid, output, 1: one-cycle pulse when rx_byte updates.
REQ-010 SHALL have port parity_err, output, 1: one-cycle pulse on odd-parity failure.
REQ-011 SHALL have port frame_err, output, 1: one-cycle pulse on a bad start bit, bad stop bit, or timeout.

Function
REQ-012 SHALL pass each raw line through a 2-flop synchronizer, then a filter that changes the filtered level only after FILTER_LEN consecutive equal synchronized samples.
REQ-013 SHALL sample filtered ps2_data on each filtered ps2_clk 1->0 transition (the "fall").
REQ-014 SHALL run FSM states IDLE, DATA, PARITY, STOP:
- IDLE: fall with data 0 -> DATA, bit count 0.
- IDLE: fall with data 1 -> frame_err pulse, stay in IDLE.
- DATA: 8 falls shift data in LSB first -> PARITY.
- PARITY: one fall captures the parity bit -> STOP.
- STOP: one fall -> IDLE.
REQ-015 At the STOP fall: stop=1 and odd parity correct -> rx_byte updated and rx_valid pulsed in the next cycle.
REQ-016 At the STOP fall: parity wrong -> parity_err pulse and no update. Parity is checked before stop.
REQ-017 At the STOP fall: stop=0 with parity correct -> frame_err pulse and no update.
REQ-018 In a non-IDLE state, TIMEOUT_CYC cycles with no fall -> frame_err pulse and return to IDLE with the partial frame discarded. The counter clears on every fall.
REQ-019 Valid byte 0xE0 -> set ext flag; no ps2_key change.
REQ-020 Valid byte 0xF0 -> set rel flag; no ps2_key change.
REQ-021 Any other valid byte:
- ps2_key[7:0] <= byte, [8] <= ext, [9] <= ~rel, [10] inverts.
- Update happens in the same cycle as rx_valid.
- ext and rel are then cleared.
REQ-022 parity_err or frame_err SHALL clear ext and rel; ps2_key holds its value.
REQ-023 Byte 0xE1 SHALL be treated as an ordinary code byte.
REQ-024 Only one error pulse SHALL be asserted per aborted frame.

Reset
REQ-025 While reset_n=0: FSM=IDLE; bit count, shift register and timeout counter = 0; ext=rel=0; ps2_key=11'h000; rx_byte=8'h00; rx_valid=parity_err=frame_err=0.
REQ-026 Reset SHALL set synchronizer and filter state to 1 (idle-high lines).
REQ-027 Reset asserted mid-frame SHALL discard the frame with no pulse output.
REQ-028 After reset release, decoding SHALL start only at the next start bit.

Structure
REQ-029 Package ps2_pkg SHALL hold:
- PS2_EXT = 8'hE0 and PS2_REL = 8'hF0;
- the FSM state enum;
- ps2_key bit-index constants KEY_EXT=8, KEY_PRESSED=9, KEY_TOGGLE=10.
REQ-030 Sub-module ps2_line_filter (synchronizer plus filter, parameter FILTER_LEN) SHALL be instantiated twice, once per line.

Verification
REQ-031 Frame 0x1C (odd parity 0) -> one rx_valid, rx_byte=8'h1C, ps2_key=11'h61C (toggle 0->1, pressed=1, ext=0).
REQ-032 Frames F0,1C after REQ-031 -> ps2_key=11'h01C (toggle 1->0, pressed=0), two rx_valid pulses.
REQ-033 Frames E0,F0,75 -> ps2_key[9:0]=10'h175 (ext=1, pressed=0), toggle inverted once.
REQ-034 Frame 0x1C with parity 1 -> parity_err pulse, no rx_valid, ps2_key unchanged.
- Then frame 0x1C with rel previously set -> pressed=1, since rel was cleared.
REQ-035 Start plus 4 data bits, then 48000 idle cycles -> exactly one frame_err pulse, FSM back to IDLE.
- A following 0x29 frame decodes correctly.
REQ-036 Two further cases:
- Glitches: 3-cycle low pulses on ps2_clk with FILTER_LEN=8 -> no bit sampled.
- Reset mid-frame: reset_n low after 5 bits -> all outputs zero, no pulses; the next full frame decodes normally.
